// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//  Bundles the two cache-side memory handshakes (icache and dcache, each
//  with a refill read port and a writeback port) and the single
//  memory_async port.
//  master : the arbiter. It receives cache requests and memory responses,
//           and it drives acks, read data and the memory request.
//  slave  : the caches plus the memory. This is the opposite direction.
//  Parameters: WIDTH (data word width), ADDR_WIDTH (address width).
interface cache_mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    // instruction cache
    logic                  i_mem_read_req;
    logic [ADDR_WIDTH-1:0] i_mem_read_addr;
    logic [WIDTH-1:0]      i_mem_read_data;
    logic                  i_mem_read_ack;
    logic                  i_mem_write_req;
    logic [ADDR_WIDTH-1:0] i_mem_write_addr;
    logic [WIDTH-1:0]      i_mem_write_data;
    logic                  i_mem_write_ack;
    // data cache
    logic                  d_mem_read_req;
    logic [ADDR_WIDTH-1:0] d_mem_read_addr;
    logic [WIDTH-1:0]      d_mem_read_data;
    logic                  d_mem_read_ack;
    logic                  d_mem_write_req;
    logic [ADDR_WIDTH-1:0] d_mem_write_addr;
    logic [WIDTH-1:0]      d_mem_write_data;
    logic                  d_mem_write_ack;
    // memory port
    logic                  mem_master_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read_write;
    logic [3:0]            mem_byte_enable;
    logic [WIDTH-1:0]      mem_data_in;
    logic [WIDTH-1:0]      mem_data_out;
    logic                  mem_ack;

    modport master (
        input  i_mem_read_req, i_mem_read_addr, i_mem_write_req,
               i_mem_write_addr, i_mem_write_data,
               d_mem_read_req, d_mem_read_addr, d_mem_write_req,
               d_mem_write_addr, d_mem_write_data,
               mem_data_out, mem_ack,
        output i_mem_read_data, i_mem_read_ack, i_mem_write_ack,
               d_mem_read_data, d_mem_read_ack, d_mem_write_ack,
               mem_master_enable, mem_addr, mem_read_write,
               mem_byte_enable, mem_data_in
    );

    modport slave (
        output i_mem_read_req, i_mem_read_addr, i_mem_write_req,
               i_mem_write_addr, i_mem_write_data,
               d_mem_read_req, d_mem_read_addr, d_mem_write_req,
               d_mem_write_addr, d_mem_write_data,
               mem_data_out, mem_ack,
        input  i_mem_read_data, i_mem_read_ack, i_mem_write_ack,
               d_mem_read_data, d_mem_read_ack, d_mem_write_ack,
               mem_master_enable, mem_addr, mem_read_write,
               mem_byte_enable, mem_data_in
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//  Shares one memory_async port between the instruction and data caches.
//  Only one access is in flight at a time. Within a cache, a writeback is
//  served before a refill. Between the two caches, the arbiter alternates
//  round-robin. The owning cache gets its read data and a level ack. That
//  ack is held until the cache drops its request.
//  Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : cache_mem_arbiter_if.master (cache handshakes + memory port)
module cache_mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_mem_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

    state_t                state_reg;
    logic                  owner_d_reg;    // 1 = data cache owns the access
    logic                  op_read_reg;    // 1 = read, 0 = write
    logic                  last_d_reg;     // 1 = previous grant went to D
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0]      wdata_reg;
    logic                  enable_reg;
    logic [WIDTH-1:0]      i_rdata_reg;
    logic [WIDTH-1:0]      d_rdata_reg;
    logic                  i_read_ack_reg;
    logic                  i_write_ack_reg;
    logic                  d_read_ack_reg;
    logic                  d_write_ack_reg;

    logic                  i_any;
    logic                  d_any;
    logic                  grant_d;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic                  owner_req;

    always_comb begin
        i_any   = bus.i_mem_read_req | bus.i_mem_write_req;
        d_any   = bus.d_mem_read_req | bus.d_mem_write_req;
        // D wins if I is silent, or if the previous grant went to I.
        grant_d = d_any & (~i_any | ~last_d_reg);
        if (grant_d) begin
            sel_write = bus.d_mem_write_req;
            sel_addr  = bus.d_mem_write_req ? bus.d_mem_write_addr : bus.d_mem_read_addr;
            sel_wdata = bus.d_mem_write_data;
        end else begin
            sel_write = bus.i_mem_write_req;
            sel_addr  = bus.i_mem_write_req ? bus.i_mem_write_addr : bus.i_mem_read_addr;
            sel_wdata = bus.i_mem_write_data;
        end
        case ({owner_d_reg, op_read_reg})
            2'b00:   owner_req = bus.i_mem_write_req;
            2'b01:   owner_req = bus.i_mem_read_req;
            2'b10:   owner_req = bus.d_mem_write_req;
            default: owner_req = bus.d_mem_read_req;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_d_reg     <= 1'b0;
            op_read_reg     <= 1'b1;
            last_d_reg      <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            enable_reg      <= 1'b0;
            i_rdata_reg     <= '0;
            d_rdata_reg     <= '0;
            i_read_ack_reg  <= 1'b0;
            i_write_ack_reg <= 1'b0;
            d_read_ack_reg  <= 1'b0;
            d_write_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Do not grant while mem_ack is high. After a reset
                    // mid-access, the memory may still be acking the
                    // aborted request, so this gate stands in for RELEASE.
                    if ((i_any | d_any) && !bus.mem_ack) begin
                        owner_d_reg <= grant_d;
                        last_d_reg  <= grant_d;
                        op_read_reg <= ~sel_write;
                        addr_reg    <= sel_addr;
                        wdata_reg   <= sel_wdata;
                        enable_reg  <= 1'b1;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        enable_reg <= 1'b0;
                        if (op_read_reg) begin
                            if (owner_d_reg) d_rdata_reg <= bus.mem_data_out;
                            else             i_rdata_reg <= bus.mem_data_out;
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (owner_req) begin
                        i_read_ack_reg  <= ~owner_d_reg &  op_read_reg;
                        i_write_ack_reg <= ~owner_d_reg & ~op_read_reg;
                        d_read_ack_reg  <=  owner_d_reg &  op_read_reg;
                        d_write_ack_reg <=  owner_d_reg & ~op_read_reg;
                    end else begin
                        // The request was dropped. This happens either after
                        // the ack was seen, or during ACCESS (no ack pulse).
                        i_read_ack_reg  <= 1'b0;
                        i_write_ack_reg <= 1'b0;
                        d_read_ack_reg  <= 1'b0;
                        d_write_ack_reg <= 1'b0;
                        state_reg       <= RELEASE;
                    end
                end
                default: begin  // RELEASE
                    if (!bus.mem_ack) state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_master_enable = enable_reg;
    assign bus.mem_addr          = addr_reg;
    assign bus.mem_read_write    = op_read_reg;
    assign bus.mem_byte_enable   = 4'hf;
    assign bus.mem_data_in       = wdata_reg;
    assign bus.i_mem_read_data   = i_rdata_reg;
    assign bus.d_mem_read_data   = d_rdata_reg;
    assign bus.i_mem_read_ack    = i_read_ack_reg;
    assign bus.i_mem_write_ack   = i_write_ack_reg;
    assign bus.d_mem_read_ack    = d_read_ack_reg;
    assign bus.d_mem_write_ack   = d_write_ack_reg;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//  Directed scoreboard bench for cache_mem_arbiter. The stimulus pushes the
//  expected memory grants and cache acks into queues. A negedge monitor pops
//  and compares each time a grant or ack rises. A small memory_async model
//  (LATENCY cycles, image word n = 0xA0000000 | n) answers the memory port.
module tb_cache_mem_arbiter;
    localparam int LATENCY = 27;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cache_mem_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

    cache_mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic rw; logic [31:0] addr; logic [31:0] data; } grant_t;
    // kind: 0 i_read, 1 i_write, 2 d_read, 3 d_write
    typedef struct packed { logic [1:0] kind; logic [31:0] data; } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];
    int     checks = 0;
    int     errors = 0;
    logic [31:0] mem [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // ---------------- memory_async model ----------------
    initial begin
        logic        busy;
        int          cnt;
        logic [9:0]  idx;
        for (int n = 0; n < 1024; n++) mem[n] = 32'hA000_0000 | n;
        bus.mem_ack = 1'b0;
        bus.mem_data_out = '0;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                if (!bus.mem_master_enable) bus.mem_ack = 1'b0;
            end else if (bus.mem_master_enable) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 1;
                end else begin
                    cnt++;
                end
                if (cnt >= LATENCY) begin
                    idx = bus.mem_addr[11:2];
                    if (bus.mem_read_write) bus.mem_data_out = mem[idx];
                    else mem[idx] = bus.mem_data_in;
                    bus.mem_ack = 1'b1;
                    busy = 1'b0;
                end
            end else begin
                busy = 1'b0;   // enable withdrawn (reset): abort
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] prev_acks = 4'b0;
    logic       prev_en = 1'b0;
    int         mack_age = 100;

    always @(negedge clk) begin
        logic [3:0] acks;
        grant_t g;
        ack_t   a;
        acks = {bus.d_mem_write_ack, bus.d_mem_read_ack, bus.i_mem_write_ack, bus.i_mem_read_ack};
        if (bus.mem_ack) mack_age = 0;
        else if (mack_age < 100) mack_age++;
        if (acks != 4'b0) chk("ack_onehot", 32'($countones(acks)), 32'd1);
        if (bus.mem_master_enable && !prev_en) begin
            if (grant_q.size() == 0) begin
                fail_now("unexpected_grant");
            end else begin
                g = grant_q.pop_front();
                $display("grant rw=%0d addr=%h data=%h", bus.mem_read_write, bus.mem_addr, bus.mem_data_in);
                chk("grant_rw", 32'(bus.mem_read_write), 32'(g.rw));
                chk("grant_addr", bus.mem_addr, g.addr);
                if (!g.rw) chk("grant_wdata", bus.mem_data_in, g.data);
                chk("byte_enable", 32'(bus.mem_byte_enable), 32'hf);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (acks[k] && !prev_acks[k]) begin
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    a = ack_q.pop_front();
                    $display("ack kind=%0d i_data=%h d_data=%h", k, bus.i_mem_read_data, bus.d_mem_read_data);
                    chk("ack_kind", 32'(k), 32'(a.kind));
                    chk("ack_latency", 32'(mack_age), 32'd2);
                    if (k == 0) chk("i_read_data", bus.i_mem_read_data, a.data);
                    if (k == 2) chk("d_read_data", bus.d_mem_read_data, a.data);
                end
            end
        end
        prev_acks = acks;
        prev_en = bus.mem_master_enable;
    end

    // ---------------- cache drivers ----------------
    task automatic set_req(input bit is_d, input bit is_wr, input logic v,
                           input logic [31:0] addr, input logic [31:0] data);
        case ({is_d, is_wr})
            2'b00: begin bus.i_mem_read_req = v; bus.i_mem_read_addr = addr; end
            2'b01: begin bus.i_mem_write_req = v; bus.i_mem_write_addr = addr; bus.i_mem_write_data = data; end
            2'b10: begin bus.d_mem_read_req = v; bus.d_mem_read_addr = addr; end
            default: begin bus.d_mem_write_req = v; bus.d_mem_write_addr = addr; bus.d_mem_write_data = data; end
        endcase
    endtask

    function automatic logic ack_of(input bit is_d, input bit is_wr);
        case ({is_d, is_wr})
            2'b00:   return bus.i_mem_read_ack;
            2'b01:   return bus.i_mem_write_ack;
            2'b10:   return bus.d_mem_read_ack;
            default: return bus.d_mem_write_ack;
        endcase
    endfunction

    task automatic access(input bit is_d, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit drop_early);
        bit seen;
        set_req(is_d, is_wr, 1'b1, addr, data);
        seen = 1'b0;
        if (drop_early) begin
            for (int n = 0; n < 400 && !seen; n++) begin
                @(posedge clk); #1;
                if (bus.mem_master_enable) seen = 1'b1;
            end
            if (!seen) fail_now("wait_enable");
            repeat (3) @(posedge clk);
            #1;
            set_req(is_d, is_wr, 1'b0, addr, data);
            return;
        end
        for (int n = 0; n < 400 && !seen; n++) begin
            @(posedge clk); #1;
            if (ack_of(is_d, is_wr)) seen = 1'b1;
        end
        if (!seen) fail_now("wait_ack");
        set_req(is_d, is_wr, 1'b0, addr, data);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            if (!ack_of(is_d, is_wr)) seen = 1'b1;
        end
        if (!seen) fail_now("wait_ack_low");
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b0, 1'b1, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b1, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", 32'(bus.mem_master_enable), 32'd0);
        chk("rst_i_read_ack", 32'(bus.i_mem_read_ack), 32'd0);
        chk("rst_i_write_ack", 32'(bus.i_mem_write_ack), 32'd0);
        chk("rst_d_read_ack", 32'(bus.d_mem_read_ack), 32'd0);
        chk("rst_d_write_ack", 32'(bus.d_mem_write_ack), 32'd0);
        chk("rst_i_read_data", bus.i_mem_read_data, 32'd0);
        chk("rst_d_read_data", bus.d_mem_read_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1. lone d read
        grant_q.push_back('{1'b1, 32'h004, 32'h0});
        ack_q.push_back('{2'd2, 32'hA000_0001});
        access(1'b1, 1'b0, 32'h004, 32'h0, 1'b0);

        // 2. d write beats d read, then read back
        grant_q.push_back('{1'b0, 32'h010, 32'hDEAD_BEEF});
        grant_q.push_back('{1'b1, 32'h020, 32'h0});
        ack_q.push_back('{2'd3, 32'h0});
        ack_q.push_back('{2'd2, 32'hA000_0008});
        fork
            access(1'b1, 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0);
            access(1'b1, 1'b0, 32'h020, 32'h0, 1'b0);
        join
        grant_q.push_back('{1'b1, 32'h010, 32'h0});
        ack_q.push_back('{2'd2, 32'hDEAD_BEEF});
        access(1'b1, 1'b0, 32'h010, 32'h0, 1'b0);

        // 3. simultaneous i/d reads after reset: D first
        pulse_reset();
        grant_q.push_back('{1'b1, 32'h00C, 32'h0});
        grant_q.push_back('{1'b1, 32'h008, 32'h0});
        ack_q.push_back('{2'd2, 32'hA000_0003});
        ack_q.push_back('{2'd0, 32'hA000_0002});
        fork
            access(1'b1, 1'b0, 32'h00C, 32'h0, 1'b0);
            access(1'b0, 1'b0, 32'h008, 32'h0, 1'b0);
        join

        // 4. continuous reads alternate D, I, D, I
        grant_q.push_back('{1'b1, 32'h100, 32'h0});
        grant_q.push_back('{1'b1, 32'h104, 32'h0});
        grant_q.push_back('{1'b1, 32'h108, 32'h0});
        grant_q.push_back('{1'b1, 32'h10C, 32'h0});
        ack_q.push_back('{2'd2, 32'hA000_0040});
        ack_q.push_back('{2'd0, 32'hA000_0041});
        ack_q.push_back('{2'd2, 32'hA000_0042});
        ack_q.push_back('{2'd0, 32'hA000_0043});
        fork
            begin
                access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
                access(1'b1, 1'b0, 32'h108, 32'h0, 1'b0);
            end
            begin
                access(1'b0, 1'b0, 32'h104, 32'h0, 1'b0);
                access(1'b0, 1'b0, 32'h10C, 32'h0, 1'b0);
            end
        join

        // 5. reset 10 cycles into an access
        grant_q.push_back('{1'b1, 32'h040, 32'h0});
        set_req(1'b1, 1'b0, 1'b1, 32'h040, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus.mem_master_enable) seen = 1'b1;
        end
        if (!seen) fail_now("t5_wait_enable");
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_enable", 32'(bus.mem_master_enable), 32'd0);
        chk("t5_acks", {28'd0, bus.d_mem_write_ack, bus.d_mem_read_ack,
                        bus.i_mem_write_ack, bus.i_mem_read_ack}, 32'd0);
        chk("t5_d_read_data", bus.d_mem_read_data, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'h040, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        grant_q.push_back('{1'b1, 32'h044, 32'h0});
        ack_q.push_back('{2'd2, 32'hA000_0011});
        access(1'b1, 1'b0, 32'h044, 32'h0, 1'b0);

        // 6. d drops its read during ACCESS, then i read is served
        grant_q.push_back('{1'b1, 32'h080, 32'h0});
        access(1'b1, 1'b0, 32'h080, 32'h0, 1'b1);
        grant_q.push_back('{1'b1, 32'h084, 32'h0});
        ack_q.push_back('{2'd0, 32'hA000_0021});
        access(1'b0, 1'b0, 32'h084, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
